// File: rtl/dap_usb_tx_ring.sv
// dap_usb_tx_ring
// Circular byte buffer for DAP response packets feeding one USB IN endpoint.
// The writer builds a packet out of groups, then closes it. Closed packet
// lengths wait in a small FIFO. The USB core drains the head packet byte by
// byte. If a transaction ends without an ACK, the same packet is replayed.
//
// Ports:
//   clk, resetn          system clock, asynchronous active-low reset
//   wr_addr/wr_data/wr_en byte write, offset from the current group head
//   grp_len/grp_finish    append a group of grp_len bytes to the open packet
//   pkt_finish/pkt_abort  close (enqueue) or discard the open packet
//   almost_full           writer must not start another packet
//   ovf_err               sticky overflow flag (write/commit/enqueue dropped)
//   queue_count           number of closed packets waiting
//   tx_done               one-cycle pulse per acknowledged packet
//   usb_endpt/usb_txact/usb_txpop/usb_txpktfin  USB core IN handshake
//   usb_txcork/usb_txdata/usb_txlen             data presented to the core
module dap_usb_tx_ring #(
  parameter int P_ENDPOINT  = 1,
  parameter int ADDR_W      = 12,
  parameter int LEN_W       = 10,
  parameter int QUEUE_DEPTH = 8,
  parameter int ALIGN_BITS  = 4,
  parameter int MAX_PKT     = 512
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [LEN_W-1:0]               wr_addr,
  input  logic [7:0]                     wr_data,
  input  logic                           wr_en,
  input  logic [LEN_W-1:0]               grp_len,
  input  logic                           grp_finish,
  input  logic                           pkt_finish,
  input  logic                           pkt_abort,
  output logic                           almost_full,
  output logic                           ovf_err,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_count,
  output logic                           tx_done,
  input  logic [3:0]                     usb_endpt,
  input  logic                           usb_txact,
  input  logic                           usb_txpop,
  input  logic                           usb_txpktfin,
  output logic                           usb_txcork,
  output logic [7:0]                     usb_txdata,
  output logic [11:0]                    usb_txlen
);

  localparam int CNT_W     = $clog2(QUEUE_DEPTH) + 1;
  localparam int IDX_W     = CNT_W - 1;
  // Space arithmetic carries two extra bits so a full RAM (2^ADDR_W) and
  // intermediate sums never wrap.
  localparam int SW        = ADDR_W + 2;
  localparam int RAM_DEPTH = 1 << ADDR_W;
  localparam logic [SW-1:0] RAM_BYTES  = SW'(RAM_DEPTH);
  localparam logic [SW-1:0] ALIGN_MASK = SW'((1 << ALIGN_BITS) - 1);
  localparam logic [SW-1:0] AF_LIMIT   = SW'(MAX_PKT + (1 << ALIGN_BITS));

  // Bytes a packet occupies in the ring: length rounded up to the alignment.
  function automatic logic [SW-1:0] footprint(input logic [LEN_W:0] len);
    return (SW'(len) + ALIGN_MASK) & ~ALIGN_MASK;
  endfunction

  logic [7:0]        ram_q [RAM_DEPTH];
  logic [ADDR_W-1:0] pkt_head_q, pkt_head_d;
  logic [ADDR_W-1:0] rd_start_q, rd_start_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LEN_W-1:0]  open_len_q, open_len_d;
  logic [SW-1:0]     used_q, used_d;
  logic [LEN_W-1:0]  len_q [QUEUE_DEPTH];
  logic [LEN_W-1:0]  len_d [QUEUE_DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;
  logic              pktfin_seen_q, pktfin_seen_d;
  logic              act_q, tx_done_q, ovf_q, ovf_d;
  logic [7:0]        txdata_q;

  logic              sel, act, txn_end, deq, enq;
  logic [SW-1:0]     head_fp, open_fp, commit_fp, free_bytes;
  logic [LEN_W:0]    grown_len, commit_len;
  logic              space_ok, queue_ok, wr_ok;
  logic [ADDR_W-1:0] wr_ptr, rd_next;
  logic [CNT_W-1:0]  enq_idx;

  assign sel        = (usb_endpt == 4'(P_ENDPOINT)) && (count_q != '0);
  assign act        = sel & usb_txact;
  // A transaction ends when the active window closes, whether the core
  // dropped txact or switched to another endpoint.
  assign txn_end    = act_q & ~act;
  assign deq        = txn_end & pktfin_seen_q;
  assign head_fp    = footprint({1'b0, len_q[0]});
  assign open_fp    = footprint({1'b0, open_len_q});
  assign free_bytes = RAM_BYTES - used_q - open_fp;
  assign grown_len  = {1'b0, open_len_q} + {1'b0, grp_len};
  assign commit_len = grp_finish ? grown_len : {1'b0, open_len_q};
  assign commit_fp  = footprint(commit_len);
  assign space_ok   = (used_q + commit_fp) <= RAM_BYTES;
  // A dequeue in the same cycle frees the slot the new entry needs.
  assign queue_ok   = (count_q != CNT_W'(QUEUE_DEPTH)) || deq;
  // The write offset must land strictly inside the free region.
  assign wr_ok      = SW'(wr_addr) < free_bytes;
  assign wr_ptr     = pkt_head_q + ADDR_W'(open_len_q) + ADDR_W'(wr_addr);
  assign rd_next    = rd_ptr_q + ADDR_W'(usb_txact & usb_txpop);
  assign enq_idx    = deq ? (count_q - 1'b1) : count_q;

  // Next-state for the writer, the length FIFO, space accounting and the
  // reader pointers. Abort outranks finish; a rejected commit changes nothing
  // but the overflow flag.
  always_comb begin
    pkt_head_d    = pkt_head_q;
    open_len_d    = open_len_q;
    used_d        = used_q;
    count_d       = count_q;
    len_d         = len_q;
    rd_start_d    = rd_start_q;
    rd_ptr_d      = rd_ptr_q;
    pktfin_seen_d = pktfin_seen_q;
    ovf_d         = ovf_q;
    enq           = 1'b0;

    if (wr_en && !wr_ok) ovf_d = 1'b1;

    if (pkt_abort) begin
      open_len_d = '0;
    end else if (pkt_finish) begin
      if (space_ok && queue_ok) begin
        enq        = 1'b1;
        pkt_head_d = pkt_head_q + commit_fp[ADDR_W-1:0];
        open_len_d = '0;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (grp_finish) begin
      if (space_ok) open_len_d = grown_len[LEN_W-1:0];
      else          ovf_d      = 1'b1;
    end

    used_d  = used_q + (enq ? commit_fp : '0) - (deq ? head_fp : '0);
    count_d = count_q + CNT_W'(enq) - CNT_W'(deq);

    if (deq) begin
      for (int i = 0; i < QUEUE_DEPTH - 1; i++) len_d[i] = len_q[i + 1];
      len_d[QUEUE_DEPTH - 1] = '0;
    end
    if (enq) len_d[enq_idx[IDX_W-1:0]] = commit_len[LEN_W-1:0];

    if (txn_end) begin
      if (pktfin_seen_q) begin
        rd_start_d = rd_start_q + head_fp[ADDR_W-1:0];
        rd_ptr_d   = rd_start_q + head_fp[ADDR_W-1:0];
      end else begin
        rd_ptr_d = rd_start_q;
      end
      pktfin_seen_d = 1'b0;
    end else if (sel && usb_txact) begin
      rd_ptr_d = rd_next;
      if (usb_txpktfin) pktfin_seen_d = 1'b1;
    end
  end

  // Packet RAM; written only when the offset fits in free space.
  always_ff @(posedge clk) begin
    if (wr_en && wr_ok) ram_q[wr_ptr] <= wr_data;
  end

  // State registers. usb_txdata is refreshed every selected cycle from the
  // address the next pop will consume.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pkt_head_q    <= '0;
      open_len_q    <= '0;
      used_q        <= '0;
      count_q       <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) len_q[i] <= '0;
      rd_start_q    <= '0;
      rd_ptr_q      <= '0;
      pktfin_seen_q <= 1'b0;
      act_q         <= 1'b0;
      tx_done_q     <= 1'b0;
      ovf_q         <= 1'b0;
      txdata_q      <= '0;
    end else begin
      pkt_head_q    <= pkt_head_d;
      open_len_q    <= open_len_d;
      used_q        <= used_d;
      count_q       <= count_d;
      for (int i = 0; i < QUEUE_DEPTH; i++) len_q[i] <= len_d[i];
      rd_start_q    <= rd_start_d;
      rd_ptr_q      <= rd_ptr_d;
      pktfin_seen_q <= pktfin_seen_d;
      act_q         <= act;
      tx_done_q     <= deq;
      ovf_q         <= ovf_d;
      if (sel) txdata_q <= ram_q[rd_next];
    end
  end

  assign almost_full = (free_bytes < AF_LIMIT) || (count_q >= CNT_W'(QUEUE_DEPTH - 1));
  assign ovf_err     = ovf_q;
  assign queue_count = count_q;
  assign tx_done     = tx_done_q;
  assign usb_txcork  = ~sel;
  assign usb_txdata  = txdata_q;
  assign usb_txlen   = sel ? 12'(len_q[0]) : 12'd0;

endmodule

// File: doc/dap_usb_tx_ring.md
Name: dap_usb_tx_ring

Overview:
- Parametrised successor to the DAP USB IN-endpoint packer.
- Buffers DAP response packets assembled from groups into a circular byte RAM and queues their lengths. Presents them to the USB device core on one IN endpoint, with retry on failed transmission.
- Adds over the previous generation: parametrised RAM/length/queue widths, true wrap-around with free-space accounting, packet abort, overflow detection, and status outputs.

Parameters:
- P_ENDPOINT, 1, IN endpoint number served.
- ADDR_W, 12, RAM address width; RAM depth = 2^ADDR_W bytes.
- LEN_W, 10, packet/group length width.
- QUEUE_DEPTH, 8, maximum queued packets (power of 2, ≥2).
- ALIGN_BITS, 4, packet start alignment = 2^ALIGN_BITS bytes.
- MAX_PKT, 512, largest packet the writer may build (almost_full margin).

Ports:
- clk  in  1  system clock.
- resetn  in  1  async active-low reset.
- wr_addr  in  LEN_W  byte offset relative to current group head.
- wr_data  in  8  byte to write.
- wr_en  in  1  write strobe.
- grp_len  in  LEN_W  length of current group.
- grp_finish  in  1  pulse: append group to open packet.
- pkt_finish  in  1  pulse: close packet and enqueue it.
- pkt_abort  in  1  pulse: discard open packet.
- almost_full  out  1  writer must not start a new packet.
- ovf_err  out  1  sticky: write/commit exceeded free space.
- queue_count  out  $clog2(QUEUE_DEPTH)+1  packets queued.
- tx_done  out  1  one-cycle pulse per successfully sent packet.
- usb_endpt  in  4  endpoint selected by USB core.
- usb_txact  in  1  IN transaction active.
- usb_txpop  in  1  core consumed one byte.
- usb_txpktfin  in  1  core reports packet handshake ACKed.
- usb_txcork  out  1  1 = nothing to send.
- usb_txdata  out  8  registered byte to send.
- usb_txlen  out  12  length of head packet (zero-extended), 0 when not selected.

Behaviour:
- Reset: all pointers, counters, queue and flags cleared. Outputs: usb_txdata=0, usb_txcork=1, usb_txlen=0, almost_full=0, ovf_err=0, tx_done=0, queue_count=0.
- Pointers are ADDR_W bits and wrap modulo 2^ADDR_W.
- Write side:
  - grp_head = pkt_head + open_len.
  - wr_en writes ram[grp_head + wr_addr].
  - grp_finish: open_len += grp_len.
  - pkt_finish: enqueue (open_len + grp_len if grp_finish is in the same cycle, else open_len).
- Footprint(len) = len rounded up to a multiple of 2^ALIGN_BITS; len=0 → footprint 0.
- At pkt_finish: pkt_head += footprint; used += footprint; open_len=0.
- pkt_abort: open_len=0, pkt_head unchanged. Abort has priority over finish in the same cycle.
- Free space = 2^ADDR_W − used − footprint(open_len).
- ovf_err sets when any of the following occurs. The offending commit/enqueue is dropped; ovf_err clears only on reset.
  - a write offset exceeds free space;
  - a commit would make free space negative;
  - pkt_finish occurs with the queue full.
- almost_full = (free < MAX_PKT + 2^ALIGN_BITS) OR (queue_count ≥ QUEUE_DEPTH−1). Combinational from registers.
- Read side:
  - sel = (usb_endpt == P_ENDPOINT) AND queue_count≠0.
  - usb_txcork = ~sel; usb_txlen = sel ? head length : 0.
  - While sel: next = rd_ptr + (usb_txact & usb_txpop); rd_ptr <= next when usb_txact; usb_txdata <= ram[next] every cycle. The byte for the next pop is therefore valid one cycle after the previous pop.
  - usb_txpktfin seen while sel&usb_txact sets pktfin_seen.
- End of transaction = falling edge of (sel & usb_txact):
  - pktfin_seen=1 (success): rd_start += footprint(head len); rd_ptr = new rd_start; dequeue; used −= footprint; tx_done pulses in the following cycle.
  - pktfin_seen=0 (failure): rd_ptr = rd_start; queue unchanged (retry).
  - pktfin_seen clears in both cases.
- Simultaneous enqueue and dequeue: queue_count unchanged. The head entry shifts out and the new entry is written at index count−1. used updates by the net of both footprints in one cycle.
- Zero-length packet: enqueued normally; usb_txlen=0 with txcork=0, so the core sends a ZLP; success dequeues with footprint 0.
- Endpoint deselected mid-transaction: treated as end-of-transaction by the rule above.

Test Plan:
- Two groups of 3 and 5 bytes, then pkt_finish → queue_count=1, usb_txlen=8; IN with pktfin → 8 bytes emitted in order, tx_done pulse, queue_count=0, next packet starts at address 16.
- IN transaction ends without usb_txpktfin → rd_ptr back to start; retry emits identical 8 bytes; queue_count unchanged until success.
- Packets of 500 bytes (footprint 512) fill toward end of a 4096-byte RAM; a packet crossing address 4095 → bytes wrap to 0 and are read back correctly; almost_full asserts when free < 528.
- pkt_finish on the same cycle as a successful dequeue with 3 queued → queue_count stays 3, usb_txlen shows the former second entry.
- pkt_abort after two groups, then a new 4-byte packet → the new packet is written at the old pkt_head; only 4 bytes are sent.
- Fill QUEUE_DEPTH entries then one more pkt_finish → ovf_err=1, queue_count=8; resetn low mid-transaction → all outputs return to reset values immediately.
